// File: rtl/imem_loader_if.sv
// Instruction-memory write port driven by the boot loader.
// The loader owns the master side; the instruction memory (or a bench) takes the slave side.
interface imem_loader_if;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: 8N1 UART boot loader that writes a little-endian word image into instruction memory.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked in state CHK.
module imem_loader #(
    parameter int CLK_DIV     = 868,
    parameter int DEPTH_WORDS = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          uart_rx,
    imem_loader_if.master imem,
    output logic          core_rst_n,
    output logic          load_busy,
    output logic          load_done,
    output logic          load_err
);

    localparam int              CW       = (CLK_DIV > 4) ? $clog2(CLK_DIV) : 2;
    localparam logic [CW-1:0]   HALF_CNT = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } state_t;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic          rx_act_q, rx_act_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_en, start_ok, byte_vld, frame_err;

    state_t        state_q, state_d;
    logic [15:0]   n_q, n_d;
    logic [15:0]   widx_q, widx_d;
    logic [1:0]    bidx_q, bidx_d;
    logic [23:0]   word_q, word_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    xor_q, xor_d;
`endif

    assign rx_en = (state_q != DONE) && (state_q != ERR);

    // Receiver: bit 0 is the start bit sampled at half a bit, bits 1..8 data, bit 9 stop.
    always_comb begin
        rx_act_d  = rx_act_q;
        rx_cnt_d  = rx_cnt_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        start_ok  = 1'b0;
        byte_vld  = 1'b0;
        frame_err = 1'b0;
        if (!rx_act_q) begin
            if (rx_en && rx_prev_q && !rx_s2_q) begin
                rx_act_d = 1'b1;
                rx_cnt_d = '0;
                rx_bit_d = 4'd0;
            end
        end else if (rx_cnt_q == ((rx_bit_q == 4'd0) ? HALF_CNT : FULL_CNT)) begin
            rx_cnt_d = '0;
            rx_bit_d = rx_bit_q + 4'd1;
            if (rx_bit_q == 4'd0) begin
                if (rx_s2_q) rx_act_d = 1'b0;
                else         start_ok = 1'b1;
            end else if (rx_bit_q == 4'd9) begin
                rx_act_d = 1'b0;
                if (rx_s2_q) byte_vld  = 1'b1;
                else         frame_err = 1'b1;
            end else begin
                rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
            end
        end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        last_d  = last_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            IDLE: if (start_ok) state_d = HDR0;
            HDR0: if (byte_vld) begin
                n_d[7:0] = rx_sh_q;
                busy_d   = 1'b1;
                state_d  = HDR1;
            end
            HDR1: if (byte_vld) begin
                n_d[15:8] = rx_sh_q;
                if ({rx_sh_q, n_q[7:0]} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
`endif
                end else if (int'({rx_sh_q, n_q[7:0]}) > DEPTH_WORDS) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (byte_vld) begin
                    bidx_d = bidx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ rx_sh_q;
`endif
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {rx_sh_q, word_q};
                        widx_d  = widx_q + 16'd1;
                        last_d  = (widx_q == n_q - 16'd1);
                    end else begin
                        word_d = {rx_sh_q, word_q[23:8]};
                    end
                end
                // The strobe cycle advances the address and, after the last word, ends the payload.
                if (we_q) begin
                    addr_d = addr_q + 32'd4;
                    if (last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: if (byte_vld) begin
                busy_d = 1'b0;
                if (rx_sh_q == xor_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end
            end
`endif
            default: ;
        endcase
        if (frame_err && state_q != DONE) begin
            state_d = ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_act_q  <= 1'b0;
            rx_cnt_q  <= '0;
            rx_bit_q  <= 4'd0;
            rx_sh_q   <= 8'd0;
            state_q   <= IDLE;
            n_q       <= 16'd0;
            widx_q    <= 16'd0;
            bidx_q    <= 2'd0;
            word_q    <= 24'd0;
            last_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= 8'd0;
`endif
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_act_q  <= rx_act_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            state_q   <= state_d;
            n_q       <= n_d;
            widx_q    <= widx_d;
            bidx_q    <= bidx_d;
            word_q    <= word_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = addr_q;
    assign imem.imem_wdata = wdata_q;
    assign core_rst_n      = done_q;
    assign load_busy       = busy_q;
    assign load_done       = done_q;
    assign load_err        = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial boot loader that writes a program image into instruction memory before the single-cycle RISC-V core runs. It receives bytes over an 8N1 UART line, assembles them into little-endian 32-bit words and writes them sequentially from address 0. It holds the core in reset until the image is loaded. It is the writer end of the instruction-memory port that the core only reads.

## Interface
Parameters:
- CLK_DIV, 868: clk cycles per UART bit (100 MHz / 115200); minimum 4.
- DEPTH_WORDS, 256: instruction-memory capacity in 32-bit words.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input; idle high; asynchronous to clk.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  32  byte address of the write; always a multiple of 4.
- imem_wdata  out  32  word to write.
- core_rst_n  out  1  active-low reset to the core; low until load completes.
- load_busy  out  1  high from the first header byte until DONE or ERR.
- load_done  out  1  sticky; the image was loaded successfully.
- load_err  out  1  sticky; the load was aborted.

## Operation
- Frame format:
  - 2-byte word count N, little-endian.
  - N×4 payload bytes; each word is sent LSB first.
  - With IMEM_LOADER_CHECKSUM_EN only: one trailing checksum byte.
- UART receiver:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge starts a bit counter that samples at CLK_DIV/2, then every CLK_DIV cycles: start bit, 8 data bits (LSB first), stop bit.
  - Start bit re-read as 1 at mid-bit: discard as a glitch and return to idle.
  - Stop bit sampled as 0: framing error, go to ERR.
- FSM states: IDLE, HDR0, HDR1, DATA, CHK (present only with the macro), DONE, ERR.
  - IDLE -> HDR0 on a valid start bit. HDR0 captures N[7:0].
  - HDR1 captures N[15:8]. Then:
    - N = 0 -> DONE.
    - N > DEPTH_WORDS -> ERR.
    - otherwise -> DATA.
  - DATA shifts bytes into a 32-bit word; a 2-bit byte index wraps 3 -> 0. At byte 3 it issues a write.
  - After write N: go to CHK (macro enabled) or DONE.
  - DONE and ERR are terminal until rst_n is asserted. uart_rx is ignored in both.
- Addressing:
  - imem_addr starts at 0 and increments by 4 after each write.
  - Last write address is 4·(N−1); it never exceeds 4·(DEPTH_WORDS−1).
- Word assembly: imem_wdata = {byte3, byte2, byte1, byte0}, where byte0 is the first byte received.
- In ERR: no further writes occur and core_rst_n stays 0.
- Reset values: imem_we 0, imem_addr 0, imem_wdata 0, core_rst_n 0, load_busy 0, load_done 0, load_err 0. FSM in IDLE, byte index 0.
- Reset during a load: every output and counter returns to its reset value immediately. The next load starts at address 0 and needs a full frame.

## Timing
- Synchronizer latency: 2 clk cycles.
- Each byte completes at its stop-bit sample cycle, S.
- For byte 3 of a word: imem_we is high for exactly cycle S+1, with imem_addr and imem_wdata stable in that cycle. imem_addr advances at S+2.
- Completion: load_done and core_rst_n go high together, one cycle after the final write strobe. With the macro, this is one cycle after the checksum byte's stop sample. For N = 0 without the macro, it is one cycle after the HDR1 stop sample.
- load_busy goes high at the HDR0 stop sample and goes low in the same cycle load_done or load_err rises.
- Back-to-back bytes with zero idle time between stop bit and next start bit are accepted.

## Configuration
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: after the payload, the FSM enters CHK and receives one byte.
  - If it equals the XOR of all 4N payload bytes: DONE.
  - Otherwise: ERR. Memory already written is left as is, and core_rst_n stays 0.
  - For N = 0 the checksum byte is still required and must be 0x00.
- Undefined: the CHK state and the XOR accumulator are absent; DONE follows the last write directly.

## Test plan
- Macro off. Send 02 00 13 00 00 00 93 00 10 00 -> writes (addr 0x0, 0x00000013) then (addr 0x4, 0x00100093). load_done and core_rst_n rise one cycle after the second strobe.
- Send count 00 00 -> no imem_we pulse; load_done = 1, core_rst_n = 1. With the macro on, load_done follows only after a 00 checksum byte.
- Send count 01 01 (257 > 256) -> load_err = 1 after HDR1, zero writes, core_rst_n stays 0. Also: a stop bit of 0 on the third payload byte -> load_err = 1, zero writes.
- Pull uart_rx low for CLK_DIV/4 cycles, then send a valid 1-word frame -> the glitch is ignored and exactly one write occurs at address 0.
- Macro on, 1-word frame with bytes 11 22 33 44:
  - checksum 0x44 -> load_done = 1;
  - checksum 0x45 -> load_err = 1, and the word 0x44332211 is still written at address 0.
- Assert rst_n after 2 payload bytes of a 2-word frame, then resend the full frame -> all outputs are 0 during reset, and the writes land at addresses 0x0 and 0x4 with correct data.
